// File: rtl/itu_intc_arb.sv
// Interrupt priority stage behind the ITU. It arbitrates the 15 timer requests
// using the IPRC/IPRD level fields and hands one level/vector to the CPU with an ack handshake.
module itu_intc_arb #(
    parameter int          VEC_BASE = 80,
    parameter logic [27:0] IPR_ADDR = 28'h5FFFF88
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        CE_R,
    input  logic        CE_F,
    input  logic [4:0]  IMIA_IRQ,
    input  logic [4:0]  IMIB_IRQ,
    input  logic [4:0]  OVI_IRQ,
    input  logic [27:0] IBUS_A,
    input  logic [31:0] IBUS_DI,
    output logic [31:0] IBUS_DO,
    input  logic [3:0]  IBUS_BA,
    input  logic        IBUS_WE,
    input  logic        IBUS_REQ,
    output logic        IBUS_BUSY,
    output logic        IBUS_ACT,
    output logic        INT_REQ,
    output logic [3:0]  INT_LVL,
    output logic [7:0]  INT_VEC,
    input  logic        INT_ACK
);

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_REQ = 1'b1} state_t;

    state_t      state_r, state_nxt_s;
    logic [15:0] iprc_r, iprd_r;
    logic [31:0] reg_do_r;
    logic [14:0] sample_r, mask_r, req_in_s, elig_s, ack_set_s;
    logic [3:0]  src_idx_r, src_nxt_s;
    logic        int_req_r, req_nxt_s;
    logic [3:0]  int_lvl_r, lvl_nxt_s;
    logic [7:0]  int_vec_r, vec_nxt_s;
    logic [3:0]  chan_lvl_s [5];
    logic [3:0]  src_lvl_s  [15];
    logic [7:0]  src_vec_s  [15];
    logic        win_found_s;
    logic [3:0]  win_idx_s, win_lvl_s;
    logic [7:0]  win_vec_s;
    logic        wr_en_s, rd_en_s;

    assign IBUS_ACT  = (IBUS_A >= IPR_ADDR) && (IBUS_A <= IPR_ADDR + 28'd3);
    assign IBUS_BUSY = 1'b0;
    assign IBUS_DO   = IBUS_ACT ? reg_do_r : 32'h0000_0000;
    assign wr_en_s   = IBUS_ACT & IBUS_WE & IBUS_REQ & CE_R;
    assign rd_en_s   = IBUS_ACT & ~IBUS_WE & IBUS_REQ;
    assign INT_REQ   = int_req_r;
    assign INT_LVL   = int_lvl_r;
    assign INT_VEC   = int_vec_r;

    assign chan_lvl_s[0] = iprc_r[7:4];
    assign chan_lvl_s[1] = iprc_r[3:0];
    assign chan_lvl_s[2] = iprd_r[15:12];
    assign chan_lvl_s[3] = iprd_r[11:8];
    assign chan_lvl_s[4] = iprd_r[7:4];

    // Source index s = 3*channel + kind, so ascending s is also the tie-break order.
    for (genvar n = 0; n < 5; n++) begin : g_ch
        assign req_in_s[3*n]     = IMIA_IRQ[n];
        assign req_in_s[3*n + 1] = IMIB_IRQ[n];
        assign req_in_s[3*n + 2] = OVI_IRQ[n];
        for (genvar k = 0; k < 3; k++) begin : g_src
            assign src_lvl_s[3*n + k] = chan_lvl_s[n];
            assign src_vec_s[3*n + k] = 8'(VEC_BASE + 4*n + k);
            assign elig_s[3*n + k]    = sample_r[3*n + k] & ~mask_r[3*n + k] & (chan_lvl_s[n] != 4'd0);
        end
    end

    // IPRC/IPRD byte-lane writes.
    always_ff @(posedge CLK) begin
        if (RST) begin
            iprc_r <= 16'h0000;
            iprd_r <= 16'h0000;
        end else if (wr_en_s) begin
            if (IBUS_BA[3]) iprc_r[15:8] <= IBUS_DI[31:24];
            if (IBUS_BA[2]) iprc_r[7:0]  <= IBUS_DI[23:16];
            if (IBUS_BA[1]) iprd_r[15:8] <= IBUS_DI[15:8];
            if (IBUS_BA[0]) iprd_r[7:0]  <= IBUS_DI[7:0];
        end
    end

    // Read-data capture on the falling-phase enable.
    always_ff @(posedge CLK) begin
        if (RST) begin
            reg_do_r <= 32'h0000_0000;
        end else if (CE_F && rd_en_s) begin
            reg_do_r <= {iprc_r, iprd_r};
        end
    end

    // Request sampling and masking; an acked source unmasks once its line is seen low.
    always_ff @(posedge CLK) begin
        if (RST) begin
            sample_r <= 15'h0000;
            mask_r   <= 15'h0000;
        end else if (CE_R) begin
            sample_r <= req_in_s;
            mask_r   <= (mask_r & sample_r) | ack_set_s;
        end
    end

    // Priority search: scanning downward with >= lets the lower index win ties.
    always_comb begin
        win_found_s = 1'b0;
        win_idx_s   = 4'd0;
        win_lvl_s   = 4'd0;
        win_vec_s   = 8'd0;
        for (int s = 14; s >= 0; s--) begin
            if (elig_s[s] && (src_lvl_s[s] >= win_lvl_s)) begin
                win_found_s = 1'b1;
                win_idx_s   = 4'(s);
                win_lvl_s   = src_lvl_s[s];
                win_vec_s   = src_vec_s[s];
            end else begin
                win_found_s = win_found_s;
            end
        end
    end

    // State and registered CPU-side outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r   <= ST_IDLE;
            int_req_r <= 1'b0;
            int_lvl_r <= 4'd0;
            int_vec_r <= 8'd0;
            src_idx_r <= 4'd0;
        end else if (CE_R) begin
            state_r   <= state_nxt_s;
            int_req_r <= req_nxt_s;
            int_lvl_r <= lvl_nxt_s;
            int_vec_r <= vec_nxt_s;
            src_idx_r <= src_nxt_s;
        end
    end

    // Next-state selection.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (win_found_s) state_nxt_s = ST_REQ;
                else             state_nxt_s = ST_IDLE;
            end
            ST_REQ: begin
                if (INT_ACK)          state_nxt_s = ST_IDLE;
                else if (win_found_s) state_nxt_s = ST_REQ;
                else                  state_nxt_s = ST_IDLE;
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Output values; an ack masks the registered source and keeps LVL/VEC.
    always_comb begin
        req_nxt_s = int_req_r;
        lvl_nxt_s = int_lvl_r;
        vec_nxt_s = int_vec_r;
        src_nxt_s = src_idx_r;
        ack_set_s = 15'h0000;
        case (state_r)
            ST_IDLE: begin
                if (win_found_s) begin
                    req_nxt_s = 1'b1;
                    lvl_nxt_s = win_lvl_s;
                    vec_nxt_s = win_vec_s;
                    src_nxt_s = win_idx_s;
                end else begin
                    req_nxt_s = 1'b0;
                end
            end
            ST_REQ: begin
                if (INT_ACK) begin
                    req_nxt_s = 1'b0;
                    ack_set_s = 15'h0001 << src_idx_r;
                end else if (win_found_s) begin
                    req_nxt_s = 1'b1;
                    lvl_nxt_s = win_lvl_s;
                    vec_nxt_s = win_vec_s;
                    src_nxt_s = win_idx_s;
                end else begin
                    req_nxt_s = 1'b0;
                end
            end
            default: req_nxt_s = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_itu_intc_arb.sv
// Scoreboard bench for itu_intc_arb: expectations are queued with the stimulus
// and compared one cycle later, #1 after the clock edge.
module tb_itu_intc_arb;

    localparam logic [27:0] IPR_ADDR = 28'h5FFFF88;

    logic        CLK, RST, CE_R, CE_F;
    logic [4:0]  IMIA_IRQ, IMIB_IRQ, OVI_IRQ;
    logic [27:0] IBUS_A;
    logic [31:0] IBUS_DI, IBUS_DO;
    logic [3:0]  IBUS_BA;
    logic        IBUS_WE, IBUS_REQ, IBUS_BUSY, IBUS_ACT;
    logic        INT_REQ, INT_ACK;
    logic [3:0]  INT_LVL;
    logic [7:0]  INT_VEC;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] exp;
    } sb_entry_t;

    sb_entry_t sb_q[$];
    int checks_cnt = 0;
    int fail_cnt   = 0;

    itu_intc_arb #(.VEC_BASE(80), .IPR_ADDR(IPR_ADDR)) dut (
        .CLK(CLK), .RST(RST), .CE_R(CE_R), .CE_F(CE_F),
        .IMIA_IRQ(IMIA_IRQ), .IMIB_IRQ(IMIB_IRQ), .OVI_IRQ(OVI_IRQ),
        .IBUS_A(IBUS_A), .IBUS_DI(IBUS_DI), .IBUS_DO(IBUS_DO), .IBUS_BA(IBUS_BA),
        .IBUS_WE(IBUS_WE), .IBUS_REQ(IBUS_REQ), .IBUS_BUSY(IBUS_BUSY), .IBUS_ACT(IBUS_ACT),
        .INT_REQ(INT_REQ), .INT_LVL(INT_LVL), .INT_VEC(INT_VEC), .INT_ACK(INT_ACK)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic expect_int(input string tag, input logic req, input logic [3:0] lvl,
                              input logic [7:0] vec);
        sb_q.push_back('{tag: {tag, ".req"}, sel: 0, exp: 32'(req)});
        sb_q.push_back('{tag: {tag, ".lvl"}, sel: 1, exp: 32'(lvl)});
        sb_q.push_back('{tag: {tag, ".vec"}, sel: 2, exp: 32'(vec)});
    endtask

    task automatic expect_req(input string tag, input logic req);
        sb_q.push_back('{tag: {tag, ".req"}, sel: 0, exp: 32'(req)});
    endtask

    task automatic expect_do(input string tag, input logic [31:0] d);
        sb_q.push_back('{tag: tag, sel: 3, exp: d});
    endtask

    task automatic tick();
        sb_entry_t e;
        logic [31:0] obs;
        @(posedge CLK);
        #1;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            case (e.sel)
                0:       obs = 32'(INT_REQ);
                1:       obs = 32'(INT_LVL);
                2:       obs = 32'(INT_VEC);
                default: obs = IBUS_DO;
            endcase
            chk(e.tag, obs, e.exp);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wr(input logic [31:0] d, input logic [3:0] ba);
        IBUS_A = IPR_ADDR; IBUS_DI = d; IBUS_BA = ba; IBUS_WE = 1'b1; IBUS_REQ = 1'b1;
        tick();
        IBUS_WE = 1'b0; IBUS_REQ = 1'b0; IBUS_A = 28'd0; IBUS_BA = 4'd0;
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] d);
        IBUS_A = IPR_ADDR + 28'd1; IBUS_WE = 1'b0; IBUS_REQ = 1'b1;
        expect_do(tag, d);
        tick();
        IBUS_REQ = 1'b0; IBUS_A = 28'd0;
        #1;
        chk({tag, ".unsel"}, IBUS_DO, 32'h0000_0000);
    endtask

    initial begin
        RST = 1'b1; CE_R = 1'b1; CE_F = 1'b1;
        IMIA_IRQ = 5'd0; IMIB_IRQ = 5'd0; OVI_IRQ = 5'd0;
        IBUS_A = 28'd0; IBUS_DI = 32'd0; IBUS_BA = 4'd0; IBUS_WE = 1'b0; IBUS_REQ = 1'b0;
        INT_ACK = 1'b0;
        tick();
        expect_int("rst", 1'b0, 4'd0, 8'd0);
        tick();
        RST = 1'b0;
        chk("busy", 32'(IBUS_BUSY), 32'd0);
        IBUS_A = IPR_ADDR + 28'd3; #1; chk("act_hi_edge", 32'(IBUS_ACT), 32'd1);
        IBUS_A = IPR_ADDR + 28'd4; #1; chk("act_out", 32'(IBUS_ACT), 32'd0);
        IBUS_A = 28'd0;

        // 1: single source, ack masks while the line is held, re-raise requests again
        wr(32'h0050_0000, 4'b1100);
        IMIA_IRQ[0] = 1'b1;
        expect_req("t1.sampled", 1'b0);
        tick();
        expect_int("t1.req", 1'b1, 4'd5, 8'd80);
        tick();
        INT_ACK = 1'b1;
        expect_int("t1.ack", 1'b0, 4'd5, 8'd80);
        tick();
        INT_ACK = 1'b0;
        for (int i = 0; i < 3; i++) begin
            expect_req("t1.masked", 1'b0);
            tick();
        end
        IMIA_IRQ[0] = 1'b0;
        idle(2);
        IMIA_IRQ[0] = 1'b1;
        expect_req("t1.rearm0", 1'b0);
        tick();
        expect_int("t1.rearm", 1'b1, 4'd5, 8'd80);
        tick();
        INT_ACK = 1'b1; tick(); INT_ACK = 1'b0;
        IMIA_IRQ[0] = 1'b0;
        idle(3);

        // 2: equal levels, lower channel wins
        wr(32'h0033_3300, 4'b1111);
        OVI_IRQ[1] = 1'b1; IMIB_IRQ[3] = 1'b1;
        tick();
        expect_int("t2.first", 1'b1, 4'd3, 8'd86);
        tick();
        INT_ACK = 1'b1;
        expect_req("t2.ack", 1'b0);
        tick();
        INT_ACK = 1'b0;
        expect_int("t2.second", 1'b1, 4'd3, 8'd93);
        tick();
        INT_ACK = 1'b1; tick(); INT_ACK = 1'b0;
        OVI_IRQ[1] = 1'b0; IMIB_IRQ[3] = 1'b0;
        idle(3);

        // 3: higher level preempts a pending request
        wr(32'h0000_0020, 4'b1111);
        IMIA_IRQ[4] = 1'b1;
        tick();
        expect_int("t3.low", 1'b1, 4'd2, 8'd96);
        tick();
        wr(32'h0000_9020, 4'b0011);
        IMIA_IRQ[2] = 1'b1;
        expect_int("t3.hold", 1'b1, 4'd2, 8'd96);
        tick();
        expect_int("t3.preempt", 1'b1, 4'd9, 8'd88);
        tick();
        INT_ACK = 1'b1;
        expect_int("t3.ack", 1'b0, 4'd9, 8'd88);
        tick();
        INT_ACK = 1'b0;
        expect_int("t3.back", 1'b1, 4'd2, 8'd96);
        tick();
        INT_ACK = 1'b1; tick(); INT_ACK = 1'b0;
        IMIA_IRQ[4] = 1'b0; IMIA_IRQ[2] = 1'b0;
        idle(3);

        // 4: level write to 0 withdraws the request; byte-lane readback
        wr(32'hA030_000A, 4'b1111);
        IMIA_IRQ[0] = 1'b1;
        tick();
        expect_int("t4.req", 1'b1, 4'd3, 8'd80);
        tick();
        wr(32'h0000_0000, 4'b0100);
        expect_req("t4.drop", 1'b0);
        tick();
        rd_chk("t4.readback", 32'hA000_000A);
        IMIA_IRQ[0] = 1'b0;
        idle(3);

        // 5: ack on the edge a higher source samples masks the old source
        wr(32'h0026_0000, 4'b1111);
        IMIA_IRQ[0] = 1'b1;
        tick();
        expect_int("t5.old", 1'b1, 4'd2, 8'd80);
        tick();
        IMIA_IRQ[1] = 1'b1; INT_ACK = 1'b1;
        expect_int("t5.ack", 1'b0, 4'd2, 8'd80);
        tick();
        INT_ACK = 1'b0;
        expect_int("t5.new", 1'b1, 4'd6, 8'd84);
        tick();
        INT_ACK = 1'b1; tick(); INT_ACK = 1'b0;
        expect_req("t5.old_masked", 1'b0);
        tick();
        IMIA_IRQ[0] = 1'b0; IMIA_IRQ[1] = 1'b0;
        idle(3);

        // 6: no CE_R freezes the handshake; reset mid-request clears everything
        wr(32'h0040_0000, 4'b1111);
        IMIA_IRQ[0] = 1'b1;
        tick();
        expect_int("t6.req", 1'b1, 4'd4, 8'd80);
        tick();
        CE_R = 1'b0; INT_ACK = 1'b1;
        expect_int("t6.no_ce", 1'b1, 4'd4, 8'd80);
        tick();
        INT_ACK = 1'b0; CE_R = 1'b1;
        RST = 1'b1;
        expect_int("t6.rst", 1'b0, 4'd0, 8'd0);
        tick();
        RST = 1'b0;
        for (int i = 0; i < 3; i++) begin
            expect_req("t6.quiet", 1'b0);
            tick();
        end
        rd_chk("t6.ipr_cleared", 32'h0000_0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
        $finish;
    end

endmodule
